// File: rtl/dffram_port_arbiter.sv
// DFFRAM port arbiter: shares the single-port DFFRAM between the management
// Wishbone bus and the housekeeping read-only port with round-robin fairness.
module dffram_port_arbiter #(
  parameter int AW = 8
) (
  input  logic          core_clk,
  input  logic          core_rst,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic          wb_ack_o,
  output logic [31:0]   wb_dat_o,
  input  logic          ro_req_i,
  input  logic [AW-1:0] ro_addr_i,
  output logic          ro_ack_o,
  output logic [31:0]   ro_data_o,
  output logic          mgmt_soc_dff_EN,
  output logic [3:0]    mgmt_soc_dff_WE,
  output logic [AW-1:0] mgmt_soc_dff_A,
  output logic [31:0]   mgmt_soc_dff_Di,
  input  logic [31:0]   mgmt_soc_dff_Do
);

  typedef enum logic [1:0] {
    IDLE,
    WB_ACK,
    RO_ACK
  } state_t;

  state_t        state, state_nx;
  logic          ro_pend, ro_pend_nx;
  logic [AW-1:0] ro_addr, ro_addr_nx;
  logic          last_ro, last_ro_nx;
  logic          wb_rd, wb_rd_nx;
  logic          wb_req;
  logic          grant_wb;
  logic          grant_ro;
  logic          idle;

  // Byte-offset and upper address bits are decoded upstream.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  assign idle     = (state == IDLE) & ~core_rst;
  assign wb_ack_o = (state == WB_ACK) & wb_cyc_i & ~core_rst;
  assign ro_ack_o = (state == RO_ACK) & ~core_rst;
  assign wb_dat_o = (wb_ack_o & wb_rd) ? mgmt_soc_dff_Do : 32'h0;

  assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  // On contention the side that lost the previous grant wins.
  assign grant_wb = idle & wb_req & (~ro_pend | last_ro);
  assign grant_ro = idle & ro_pend & ~grant_wb;

  always_comb begin
    state_nx        = state;
    ro_pend_nx      = ro_pend;
    ro_addr_nx      = ro_addr;
    last_ro_nx      = last_ro;
    wb_rd_nx        = wb_rd;
    mgmt_soc_dff_EN = 1'b0;
    mgmt_soc_dff_WE = 4'h0;
    mgmt_soc_dff_A  = '0;
    mgmt_soc_dff_Di = 32'h0;
    unique case (state)
      IDLE: begin
        if (grant_wb) begin
          mgmt_soc_dff_EN = 1'b1;
          mgmt_soc_dff_WE = wb_we_i ? wb_sel_i : 4'h0;
          mgmt_soc_dff_A  = wb_adr_i[AW+1:2];
          mgmt_soc_dff_Di = wb_dat_i;
          wb_rd_nx        = ~wb_we_i;
          last_ro_nx      = 1'b0;
          state_nx        = WB_ACK;
        end else if (grant_ro) begin
          mgmt_soc_dff_EN = 1'b1;
          mgmt_soc_dff_A  = ro_addr;
          ro_pend_nx      = 1'b0;
          last_ro_nx      = 1'b1;
          state_nx        = RO_ACK;
        end
      end
      WB_ACK:  state_nx = IDLE;
      RO_ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A fresh request outranks the clear from a grant in the same cycle.
    if (ro_req_i) begin
      ro_pend_nx = 1'b1;
      ro_addr_nx = ro_addr_i;
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state     <= IDLE;
      ro_pend   <= 1'b0;
      ro_addr   <= '0;
      last_ro   <= 1'b1;
      wb_rd     <= 1'b0;
      ro_data_o <= 32'h0;
    end else begin
      state   <= state_nx;
      ro_pend <= ro_pend_nx;
      ro_addr <= ro_addr_nx;
      last_ro <= last_ro_nx;
      wb_rd   <= wb_rd_nx;
      if (state == RO_ACK)
        ro_data_o <= mgmt_soc_dff_Do;
    end
  end

endmodule

// File: doc/dffram_port_arbiter.md
Name: dffram_port_arbiter

Overview:
- Sits between the management SoC's internal Wishbone bus, the housekeeping SRAM read-only port, and the single-port DFFRAM.
- Drives the mgmt_soc_dff_EN/WE/A/Di bus and consumes mgmt_soc_dff_Do.
- Arbitrates CPU read/write traffic against housekeeping read-only requests and returns data on each requester's own handshake.
- Replaces direct CPU-only ownership of the DFFRAM interface.

Parameters:
- AW, 8, DFFRAM word-address width; the RAM holds 2^AW 32-bit words.

Ports:
- core_clk  in  1  system clock; all logic is on the rising edge.
- core_rst  in  1  synchronous reset, active-high.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  4  byte-lane selects.
- wb_adr_i  in  32  byte address; only bits [AW+1:2] are used.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  Wishbone acknowledge, single-cycle pulse.
- wb_dat_o  out  32  read data; valid only while wb_ack_o=1, else 0.
- ro_req_i  in  1  housekeeping read request, single-cycle pulse, already in the core_clk domain.
- ro_addr_i  in  AW  housekeeping word address, sampled when ro_req_i=1.
- ro_ack_o  out  1  read-complete pulse.
- ro_data_o  out  32  last read-only result, held until the next ro_ack_o.
- mgmt_soc_dff_EN  out  1  RAM enable.
- mgmt_soc_dff_WE  out  4  RAM byte write enables.
- mgmt_soc_dff_A  out  AW  RAM word address.
- mgmt_soc_dff_Di  out  32  RAM write data.
- mgmt_soc_dff_Do  in  32  RAM read data; valid the cycle after EN=1 with WE=0.

Behaviour:
- Reset: core_rst is synchronous and active-high. It forces:
  - state=IDLE; ro_pend=0; last_grant=RO (so WB wins the first contention);
  - wb_ack_o=0, ro_ack_o=0, ro_data_o=0;
  - EN=0, WE=0, A=0, Di=0 (RAM outputs gated to 0 while core_rst=1).
- RO capture: ro_req_i=1 sets ro_pend=1 and registers ro_addr. A new ro_req_i while pending overwrites the address (last wins); only one ro_ack_o is produced.
- WB request condition: wb_cyc_i & wb_stb_i & ~wb_ack_o.
- States: IDLE, WB_ACK, RO_ACK.
- IDLE, no request pending: RAM bus idle (EN=0, WE=0).
- IDLE, grant cycle (same cycle as request, combinational drive):
  - WB granted: EN=1, A=wb_adr_i[AW+1:2], Di=wb_dat_i, WE = wb_we_i ? wb_sel_i : 4'b0. Go to WB_ACK.
  - RO granted: EN=1, WE=0, A=ro_addr. Clear ro_pend, unless ro_req_i is also 1 in this cycle, in which case ro_pend stays set with the new address. Go to RO_ACK.
- Contention (WB request and ro_pend both true in IDLE): round-robin; the grant goes to the requester that did not win the previous grant. last_grant updates on every grant.
- WB_ACK (one cycle):
  - wb_ack_o=1 only if wb_cyc_i is still 1; otherwise ack is suppressed. A write has already committed either way.
  - For reads, wb_dat_o=mgmt_soc_dff_Do.
  - EN=0 this cycle; next state IDLE.
- RO_ACK (one cycle): ro_ack_o=1; ro_data_o<=mgmt_soc_dff_Do, registered and visible from the following cycle. EN=0; next state IDLE.
- Latency and throughput:
  - Request-to-ack is 1 cycle when uncontended.
  - At most one RAM access every 2 cycles.
  - Worst-case wait for either requester is 2 cycles under contention (fairness bound).
- Write data is never returned on wb_dat_o; it reads 0 on write acks.
- Address bits above AW+1 are ignored; decode is done upstream. Wrap-around follows naturally.
- Reset asserted in WB_ACK or RO_ACK: the ack is suppressed that cycle and the pending RO request is dropped.

Test Plan:
- WB write adr=0x10, dat=0xDEADBEEF, sel=4'hF, then read adr=0x10 -> EN pulses with WE=4'hF then 4'h0; A=4 both times; each wb_ack_o 1 cycle after grant; read wb_dat_o=0xDEADBEEF.
- Byte write sel=4'b0010, dat=0x0000AA00 over 0x11223344, read back -> 0x1122AA44.
- ro_req_i with ro_addr_i=4, RAM idle -> EN next-edge read of A=4; ro_ack_o 1 cycle after grant; ro_data_o=0x1122AA44 and held until the next ro_ack_o.
- WB read and ro_pend both present in IDLE after reset -> WB granted first, RO granted 2 cycles later. Repeat with back-to-back WB requests -> grants alternate WB/RO/WB.
- Two ro_req_i pulses (addr 3 then addr 7) while a WB access is in WB_ACK -> single ro_ack_o with data from addr 7.
- core_rst=1 during the WB_ACK of a read, with ro_pend=1 -> no wb_ack_o, no ro_ack_o, EN=0; after release, RAM bus idle until a new request.
